bcd_time_cnt: RTL and testbench
===============================

// Module: bcd_time_cnt
// PURPOSE
//   Parametrised BCD time counter for the FND watch datapath. Counts SS, MM:SS or HH:MM:SS
//   one step per enable tick, up or down. Supports synchronous load of a preset value
//   with range checking, and a clear input. Output feeds the FND digit mux/decoder;
//   oWRAP marks a full-range rollover for alarm/timer logic.
// PARAMETERS
//   N_FIELDS  2   number of 2-digit fields: 1=SS, 2=MM:SS, 3=HH:MM:SS (legal 1..3)
//   HR_MOD    24  modulus of field 2 (hours) when N_FIELDS=3; legal 2..99 (12, 24 typical)
// PORTS
//   iCLK        in   1            system clock
//   iRESETn     in   1            synchronous reset, active-low
//   iEN_1       in   1            count tick, 1-cycle pulse (1 Hz strobe)
//   iDOWN       in   1            count direction: 0=up, 1=down; sampled only on a tick
//   iCLR        in   1            synchronous clear to all-zero
//   iLOAD       in   1            synchronous load of iLOAD_DATA
//   iLOAD_DATA  in   8*N_FIELDS   preset value, packed BCD, same layout as oDATA_CNT
//   oDATA_CNT   out  8*N_FIELDS   count; field k = [8k+7:8k], tens nibble high; field 0=SS
//   oWRAP       out  1            1-cycle pulse: count wrapped (max->0 up, 0->max down)
//   oLOAD_ERR   out  1            1-cycle pulse: load rejected, value out of range
//   oZERO       out  1            combinational: oDATA_CNT is all zeros
// BEHAVIOUR
//   - Reset: iRESETn=0 at posedge -> oDATA_CNT=0, oWRAP=0, oLOAD_ERR=0. Overrides all inputs.
//   - Priority per cycle: reset > iCLR > iLOAD > iEN_1 > hold.
//   - Field moduli: fields 0, 1 = 60 (units 0-9, tens 0-5). Field 2 = HR_MOD
//     (units 0-9; wraps at HR_MOD-1, e.g. 23 -> 00 for 24).
//   - Up, on tick: units+1. Units 9 -> 0 with carry to tens. Field at max -> 00,
//     with carry into the next field. Top field at max with all lower fields at max
//     -> full count 0, oWRAP=1 next cycle.
//   - Down, on tick: units-1. Units 0 -> 9 with borrow. Field at 00 -> max (59 or HR_MOD-1),
//     with borrow from the next field. All-zero -> full max value
//     (e.g. 23:59:59), oWRAP=1.
//   - Latency: oDATA_CNT and oWRAP update on the same posedge that samples the tick/load;
//     no pipelining. oWRAP/oLOAD_ERR are high for exactly one cycle, else 0.
//   - iCLR: count=0, oWRAP=0, oLOAD_ERR=0. Any tick or load in the same cycle is dropped.
//   - iLOAD valid when every nibble <=9, tens of fields 0/1 <=5, field 2 value <HR_MOD.
//     Valid: count=iLOAD_DATA. Invalid: count held, oLOAD_ERR=1 next cycle.
//     A tick coincident with a load is dropped either way; never oWRAP on a load.
//   - Counter never leaves the legal range, so no illegal-state recovery is needed;
//     reset mid-count simply returns to 0.
//   - iDOWN may change every cycle; only its value at a tick edge matters.
// TESTING
//   1 Reset: drive all inputs active with iRESETn=0 -> oDATA_CNT=0, oWRAP=0, oLOAD_ERR=0,
//     oZERO=1.
//   2 N_FIELDS=2 up: load 0x5958, 2 ticks -> 0x5959, then 0x0000 with oWRAP=1 for 1 cycle;
//     0x0009+tick -> 0x0010.
//   3 N_FIELDS=3 HR_MOD=24 down: from 0x000000 one tick -> 0x235959, oWRAP=1;
//     0x010000 -> 0x005959, oWRAP=0.
//   4 Load checks: 0x0060, 0x00A0 and (N=3) 0x240000 -> count unchanged, oLOAD_ERR=1;
//     0x235959 accepted, oLOAD_ERR=0.
//   5 Priority: iCLR+iLOAD+iEN_1 same cycle -> 0. iLOAD+iEN_1 -> loaded value exact,
//     no increment.
//   6 HR_MOD=12 up: 0x115959 + tick -> 0x000000, oWRAP=1; iEN_1 low 10 cycles -> count held.

Source files
------------

// File: rtl/bcd_time_cnt.sv
// BCD time counter: SS, MM:SS or HH:MM:SS, counting up or down one step per tick,
// with range-checked preset load, clear, and full-range wrap pulse.
module bcd_time_cnt #(
    parameter int N_FIELDS = 2,
    parameter int HR_MOD   = 24
) (
    input  logic                  iCLK,
    input  logic                  iRESETn,
    input  logic                  iEN_1,
    input  logic                  iDOWN,
    input  logic                  iCLR,
    input  logic                  iLOAD,
    input  logic [8*N_FIELDS-1:0] iLOAD_DATA,
    output logic [8*N_FIELDS-1:0] oDATA_CNT,
    output logic                  oWRAP,
    output logic                  oLOAD_ERR,
    output logic                  oZERO
);

    localparam int W = 8*N_FIELDS;
    localparam logic [3:0] HR_MAX_T = 4'((HR_MOD-1)/10);
    localparam logic [3:0] HR_MAX_U = 4'((HR_MOD-1)%10);

    logic [W-1:0] cnt;
    logic [W-1:0] cntUp;
    logic [W-1:0] cntDn;
    logic         upWrap;
    logic         dnWrap;
    logic         loadOk;
    logic         carry;
    logic         borrow;
    logic [7:0]   fld;
    logic         wrapR;
    logic         loadErrR;

    function automatic logic [7:0] fieldMax(input int k);
        return (k == 2) ? {HR_MAX_T, HR_MAX_U} : 8'h59;
    endfunction

    function automatic logic fieldValid(input int k, input logic [7:0] f);
        if (f[3:0] > 4'd9 || f[7:4] > 4'd9)
            return 1'b0;
        if (k == 2)
            return (int'(f[7:4])*10 + int'(f[3:0])) < HR_MOD;
        return f[7:4] <= 4'd5;
    endfunction

    function automatic logic [7:0] stepUp(input logic [7:0] f, input logic [7:0] mx);
        if (f == mx)
            return 8'h00;
        if (f[3:0] == 4'd9)
            return {f[7:4] + 4'd1, 4'd0};
        return {f[7:4], f[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] stepDown(input logic [7:0] f, input logic [7:0] mx);
        if (f == 8'h00)
            return mx;
        if (f[3:0] == 4'd0)
            return {f[7:4] - 4'd1, 4'd9};
        return {f[7:4], f[3:0] - 4'd1};
    endfunction

    // Ripple carry/borrow across fields; a field steps only when all lower fields roll over
    always_comb begin
        cntUp  = cnt;
        cntDn  = cnt;
        carry  = 1'b1;
        borrow = 1'b1;
        loadOk = 1'b1;
        fld    = 8'h00;
        for (int k = 0; k < N_FIELDS; k++) begin
            fld = cnt[8*k +: 8];
            if (carry)
                cntUp[8*k +: 8] = stepUp(fld, fieldMax(k));
            if (borrow)
                cntDn[8*k +: 8] = stepDown(fld, fieldMax(k));
            carry  = carry  & (fld == fieldMax(k));
            borrow = borrow & (fld == 8'h00);
            loadOk = loadOk & fieldValid(k, iLOAD_DATA[8*k +: 8]);
        end
        upWrap = carry;
        dnWrap = borrow;
    end

    always_ff @(posedge iCLK) begin
        if (!iRESETn) begin
            cnt      <= '0;
            wrapR    <= 1'b0;
            loadErrR <= 1'b0;
        end else begin
            wrapR    <= 1'b0;
            loadErrR <= 1'b0;
            if (iCLR) begin
                cnt <= '0;
            end else if (iLOAD) begin
                if (loadOk)
                    cnt <= iLOAD_DATA;
                else
                    loadErrR <= 1'b1;
            end else if (iEN_1) begin
                if (iDOWN) begin
                    cnt   <= cntDn;
                    wrapR <= dnWrap;
                end else begin
                    cnt   <= cntUp;
                    wrapR <= upWrap;
                end
            end
        end
    end

    assign oDATA_CNT = cnt;
    assign oWRAP     = wrapR;
    assign oLOAD_ERR = loadErrR;
    assign oZERO     = (cnt == '0);

endmodule

// File: tb/tb_bcd_time_cnt.sv
// Scoreboard bench: three counter configurations share one stimulus stream and are
// checked against a seconds-since-zero reference model.
module tb_bcd_time_cnt;

    logic        iCLK = 1'b0;
    logic        iRESETn = 1'b0;
    logic        iEN_1 = 1'b0;
    logic        iDOWN = 1'b0;
    logic        iCLR = 1'b0;
    logic        iLOAD = 1'b0;
    logic [23:0] iLOAD_DATA = '0;

    logic [15:0] cnt0;
    logic [23:0] cnt1;
    logic [23:0] cnt2;
    logic [2:0]  wrapO;
    logic [2:0]  errO;
    logic [2:0]  zeroO;

    always #5 iCLK = ~iCLK;

    bcd_time_cnt #(.N_FIELDS(2), .HR_MOD(24)) uMmss (
        .iCLK(iCLK), .iRESETn(iRESETn), .iEN_1(iEN_1), .iDOWN(iDOWN), .iCLR(iCLR),
        .iLOAD(iLOAD), .iLOAD_DATA(iLOAD_DATA[15:0]), .oDATA_CNT(cnt0),
        .oWRAP(wrapO[0]), .oLOAD_ERR(errO[0]), .oZERO(zeroO[0]));

    bcd_time_cnt #(.N_FIELDS(3), .HR_MOD(24)) uHms24 (
        .iCLK(iCLK), .iRESETn(iRESETn), .iEN_1(iEN_1), .iDOWN(iDOWN), .iCLR(iCLR),
        .iLOAD(iLOAD), .iLOAD_DATA(iLOAD_DATA), .oDATA_CNT(cnt1),
        .oWRAP(wrapO[1]), .oLOAD_ERR(errO[1]), .oZERO(zeroO[1]));

    bcd_time_cnt #(.N_FIELDS(3), .HR_MOD(12)) uHms12 (
        .iCLK(iCLK), .iRESETn(iRESETn), .iEN_1(iEN_1), .iDOWN(iDOWN), .iCLR(iCLR),
        .iLOAD(iLOAD), .iLOAD_DATA(iLOAD_DATA), .oDATA_CNT(cnt2),
        .oWRAP(wrapO[2]), .oLOAD_ERR(errO[2]), .oZERO(zeroO[2]));

    typedef struct packed {
        logic [2:0][23:0] data;
        logic [2:0]       wrap;
        logic [2:0]       err;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: each counter is an integer seconds value modulo its full range
    int nFld[3]  = '{2, 3, 3};
    int hrMod[3] = '{24, 24, 12};
    int modV[3]  = '{3600, 86400, 43200};
    int val[3]   = '{0, 0, 0};

    function automatic logic [23:0] toBcd(input int v, input int n);
        logic [23:0] r;
        int x;
        r = '0;
        for (int f = 0; f < n; f++) begin
            x = (f < 2) ? v % 60 : v;
            r = r | (24'(((x / 10) << 4) | (x % 10)) << (8*f));
            v = v / 60;
        end
        return r;
    endfunction

    function automatic void fromBcd(input logic [23:0] d, input int n, input int hr,
                                    output bit ok, output int v);
        logic [23:0] s;
        int t, u, lim, mult;
        ok = 1'b1;
        v = 0;
        mult = 1;
        for (int f = 0; f < n; f++) begin
            s = d >> (8*f);
            t = int'(s[7:4]);
            u = int'(s[3:0]);
            lim = (f == 2) ? hr : 60;
            if (u > 9 || t > 9 || t*10 + u >= lim)
                ok = 1'b0;
            v = v + (t*10 + u) * mult;
            mult = mult * 60;
        end
    endfunction

    task automatic drive(input bit rst, input bit clr, input bit ld, input bit en,
                         input bit dn, input logic [23:0] d);
        exp_t e;
        bit ok;
        int v;
        @(negedge iCLK);
        #1;
        iRESETn = ~rst;
        iCLR = clr;
        iLOAD = ld;
        iEN_1 = en;
        iDOWN = dn;
        iLOAD_DATA = d;
        e = '0;
        for (int i = 0; i < 3; i++) begin
            if (rst || clr) begin
                val[i] = 0;
            end else if (ld) begin
                fromBcd(d, nFld[i], hrMod[i], ok, v);
                if (ok)
                    val[i] = v;
                else
                    e.err[i] = 1'b1;
            end else if (en) begin
                if (dn) begin
                    e.wrap[i] = (val[i] == 0);
                    val[i] = (val[i] + modV[i] - 1) % modV[i];
                end else begin
                    e.wrap[i] = (val[i] == modV[i] - 1);
                    val[i] = (val[i] + 1) % modV[i];
                end
            end
            e.data[i] = toBcd(val[i], nFld[i]);
        end
        sbq.push_back(e);
    endtask

    task automatic tick(input bit dn);
        drive(0, 0, 0, 1, dn, '0);
    endtask

    task automatic load(input logic [23:0] d);
        drive(0, 0, 1, 0, 0, d);
    endtask

    always @(negedge iCLK) begin
        exp_t e;
        logic [23:0] act;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            for (int i = 0; i < 3; i++) begin
                act = (i == 0) ? {8'h00, cnt0} : (i == 1) ? cnt1 : cnt2;
                checks += 4;
                if (act !== e.data[i]) begin
                    failures++;
                    $display("FAIL data[%0d] t=%0t got=%h exp=%h", i, $time, act, e.data[i]);
                end
                if (wrapO[i] !== e.wrap[i]) begin
                    failures++;
                    $display("FAIL wrap[%0d] t=%0t got=%b exp=%b", i, $time, wrapO[i], e.wrap[i]);
                end
                if (errO[i] !== e.err[i]) begin
                    failures++;
                    $display("FAIL loaderr[%0d] t=%0t got=%b exp=%b", i, $time, errO[i], e.err[i]);
                end
                if (zeroO[i] !== (e.data[i] == 24'h0)) begin
                    failures++;
                    $display("FAIL zero[%0d] t=%0t got=%b exp=%b", i, $time, zeroO[i],
                             (e.data[i] == 24'h0));
                end
            end
        end
    end

    initial begin
        logic [23:0] d;
        int r;
        int budget;
        // Reset with every other input asserted
        drive(1, 1, 1, 1, 1, 24'h235959);
        drive(1, 0, 1, 1, 0, 24'h115958);
        // Up across the minute/hour boundary
        load(24'h005958);
        tick(0);
        tick(0);
        load(24'h000009);
        tick(0);
        // Down from zero and across an hour borrow
        drive(0, 1, 0, 0, 0, '0);
        tick(1);
        load(24'h010000);
        tick(1);
        // Range checks on load
        load(24'h000060);
        load(24'h0000A0);
        load(24'h240000);
        load(24'h120000);
        load(24'h235959);
        load(24'h115959);
        // Priority
        drive(0, 1, 1, 1, 0, 24'h001234);
        drive(0, 0, 1, 1, 0, 24'h001234);
        drive(0, 0, 1, 1, 1, 24'h005555);
        // 12-hour wrap, then hold with no ticks while direction toggles
        load(24'h115959);
        tick(0);
        for (int i = 0; i < 10; i++)
            drive(0, 0, 0, 0, i[0], 24'hFFFFFF);
        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            r = int'($urandom_range(0, 999));
            if ($urandom_range(0, 1) == 1)
                d = toBcd(int'($urandom_range(0, 86399)), 3);
            else
                d = 24'($urandom);
            if (r < 5)
                drive(1, $urandom_range(0, 1), $urandom_range(0, 1), 1, 0, d);
            else if (r < 20)
                drive(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), 0, d);
            else if (r < 70)
                drive(0, 0, 1, $urandom_range(0, 1), $urandom_range(0, 1), d);
            else
                drive(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), d);
        end
        drive(0, 0, 0, 0, 0, '0);
        budget = 0;
        while (sbq.size() > 0 && budget < 20) begin
            @(posedge iCLK);
            budget++;
        end
        if (sbq.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain left=%0d required=0", sbq.size());
        end
        @(posedge iCLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
